// File: rtl/pipeline_hazard_control_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_control_pkg
// Shared definitions for the pipeline hazard controller:
//   - hz_state_t   : controller FSM state encoding (RUN / MEM_WAIT / HALT)
//   - hz_ctrl_t    : bundle of pipeline-register enables and NOP injects
//   - hz_decode()  : priority decode of the hazard inputs into hz_ctrl_t
//   - DEFAULT_MEM_TIMEOUT, counter widths
// ---------------------------------------------------------------------------
package pipeline_hazard_control_pkg;

    localparam int unsigned DEFAULT_MEM_TIMEOUT = 255;
    localparam int          WAIT_CNT_W          = 16;
    localparam int          PERF_CNT_W          = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic if_id_flush;
        logic id_ex_bubble;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    // Priority: HALT > Mem_Busy > taken branch > load-use stall > normal.
    // A memory stall freezes every stage, so nothing is squashed or bubbled
    // upstream; any branch/stall request is simply re-presented and serviced
    // once the memory releases.
    function automatic hz_ctrl_t hz_decode(
        input logic halt,
        input logic mem_busy,
        input logic br_taken,
        input logic do_stall
    );
        hz_ctrl_t c;
        c.pc_we         = 1'b1;
        c.if_id_we      = 1'b1;
        c.id_ex_we      = 1'b1;
        c.ex_mem_we     = 1'b1;
        c.if_id_flush   = 1'b0;
        c.id_ex_bubble  = 1'b0;
        c.mem_wb_bubble = 1'b0;
        if (halt) begin
            c = '0;
        end else if (mem_busy) begin
            c               = '0;
            c.mem_wb_bubble = 1'b1;
        end else if (br_taken) begin
            // ID instruction is wrong-path, so a coincident stall is moot.
            c.if_id_flush  = 1'b1;
            c.id_ex_bubble = 1'b1;
        end else if (do_stall) begin
            c.pc_we        = 1'b0;
            c.if_id_we     = 1'b0;
            c.id_ex_bubble = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_control_perf_counter.sv
// ---------------------------------------------------------------------------
// hazard_perf_counter
// Free-running event counter that wraps from all-ones back to zero.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (clears the count)
//   i_en     : count this edge
//   o_count  : current count
// ---------------------------------------------------------------------------
module hazard_perf_counter
    import pipeline_hazard_control_pkg::*;
#(
    parameter int WIDTH = PERF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_control.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_control
// Central stall/flush controller for a 5-stage in-order pipeline. Decodes
// load-use stalls, taken branches and data-memory back-pressure into
// pipeline-register enables and NOP injects, halts the pipe if memory stays
// busy for MEM_TIMEOUT consecutive cycles, and keeps two perf counters.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   Do_Stall            : load-use hazard from the ID stall checker
//   Branch_Taken_EX     : taken branch/jump resolved in EX
//   Mem_Busy            : MEM-stage access cannot complete this cycle
//   Timeout_Clear       : pulse, leaves HALT
//   PC_Write_En .. EX_MEM_Write_En : pipeline register load enables
//   IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble : NOP injects
//   Halted              : high while in HALT
//   Stall_Cycles        : cycles with PC_Write_En=0
//   Flush_Count         : cycles with IF_ID_Flush=1
// Parameter MEM_TIMEOUT must lie in 1..65535 (16-bit wait counter).
// ---------------------------------------------------------------------------
module pipeline_hazard_control
    import pipeline_hazard_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Do_Stall,
    input  logic        Branch_Taken_EX,
    input  logic        Mem_Busy,
    input  logic        Timeout_Clear,
    output logic        PC_Write_En,
    output logic        IF_ID_Write_En,
    output logic        ID_EX_Write_En,
    output logic        EX_MEM_Write_En,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        MEM_WB_Bubble,
    output logic        Halted,
    output logic [31:0] Stall_Cycles,
    output logic [31:0] Flush_Count
);

    // Last wait-count value before the timeout fires.
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);
    localparam bit                    TIMEOUT_ONE  = (MEM_TIMEOUT == 1);

    hz_state_t             r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    hz_ctrl_t              w_ctrl;
    logic                  w_halt;

    assign w_halt = (r_state == ST_HALT);

    // Outputs are a zero-latency decode of the state and live inputs; in
    // MEM_WAIT with Mem_Busy low this is identical to RUN, which is what
    // lets a branch/stall held during the wait be serviced immediately.
    always_comb begin
        w_ctrl = hz_decode(w_halt, Mem_Busy, Branch_Taken_EX, Do_Stall);
    end

    assign PC_Write_En     = w_ctrl.pc_we;
    assign IF_ID_Write_En  = w_ctrl.if_id_we;
    assign ID_EX_Write_En  = w_ctrl.id_ex_we;
    assign EX_MEM_Write_En = w_ctrl.ex_mem_we;
    assign IF_ID_Flush     = w_ctrl.if_id_flush;
    assign ID_EX_Bubble    = w_ctrl.id_ex_bubble;
    assign MEM_WB_Bubble   = w_ctrl.mem_wb_bubble;
    assign Halted          = w_halt;

    // r_wait_cnt holds the number of consecutive busy edges seen so far.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (Mem_Busy) begin
                        r_state    <= TIMEOUT_ONE ? ST_HALT : ST_MEM_WAIT;
                        r_wait_cnt <= WAIT_CNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (Mem_Busy) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (r_wait_cnt == TIMEOUT_LAST) begin
                            r_state <= ST_HALT;
                        end
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                ST_HALT: begin
                    if (Timeout_Clear) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // HALT holds PC_Write_En low, so stall cycles keep accruing there.
    hazard_perf_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (~w_ctrl.pc_we),
        .o_count (Stall_Cycles)
    );

    hazard_perf_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_ctrl.if_id_flush),
        .o_count (Flush_Count)
    );

endmodule

// File: tb/tb_pipeline_hazard_control.sv
module tb_pipeline_hazard_control;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Do_Stall = 1'b0;
    logic        Branch_Taken_EX = 1'b0;
    logic        Mem_Busy = 1'b0;
    logic        Timeout_Clear = 1'b0;
    logic        PC_Write_En, IF_ID_Write_En, ID_EX_Write_En, EX_MEM_Write_En;
    logic        IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble, Halted;
    logic [31:0] Stall_Cycles, Flush_Count;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    pipeline_hazard_control #(.MEM_TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Do_Stall        (Do_Stall),
        .Branch_Taken_EX (Branch_Taken_EX),
        .Mem_Busy        (Mem_Busy),
        .Timeout_Clear   (Timeout_Clear),
        .PC_Write_En     (PC_Write_En),
        .IF_ID_Write_En  (IF_ID_Write_En),
        .ID_EX_Write_En  (ID_EX_Write_En),
        .EX_MEM_Write_En (EX_MEM_Write_En),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Bubble    (ID_EX_Bubble),
        .MEM_WB_Bubble   (MEM_WB_Bubble),
        .Halted          (Halted),
        .Stall_Cycles    (Stall_Cycles),
        .Flush_Count     (Flush_Count)
    );

    always #5 clk = ~clk;

    // Control vector: {pc, ifid, idex, exmem, flush, idex_bub, memwb_bub, halted}
    function automatic logic [7:0] exp_ctrl(input bit halt, input logic st, br, mb);
        if (halt)  return 8'h01;
        if (mb)    return 8'h02;
        if (br)    return 8'hFC;
        if (st)    return 8'h34;
        return 8'hF0;
    endfunction

    function automatic logic [7:0] dut_ctrl();
        return {PC_Write_En, IF_ID_Write_En, ID_EX_Write_En, EX_MEM_Write_En,
                IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble, Halted};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: halted flag plus length of the current busy streak.
    bit          m_halt;
    int unsigned m_streak;
    logic [31:0] m_stall_inc, m_flush;
    logic [31:0] stall_bias = 32'd0;
    logic [7:0]  e_now;

    assign e_now = exp_ctrl(m_halt, Do_Stall, Branch_Taken_EX, Mem_Busy);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_halt      <= 1'b0;
            m_streak    <= 0;
            m_stall_inc <= 32'd0;
            m_flush     <= 32'd0;
        end else begin
            m_stall_inc <= m_stall_inc + {31'd0, ~e_now[7]};
            m_flush     <= m_flush + {31'd0, e_now[3]};
            if (m_halt) begin
                if (Timeout_Clear) begin
                    m_halt   <= 1'b0;
                    m_streak <= 0;
                end
            end else if (Mem_Busy) begin
                m_streak <= m_streak + 1;
                if (m_streak + 1 >= TO) m_halt <= 1'b1;
            end else begin
                m_streak <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_ctrl", 32'(dut_ctrl()), 32'(e_now));
            chk("cyc_stall_cycles", Stall_Cycles, stall_bias + m_stall_inc);
            chk("cyc_flush_count", Flush_Count, m_flush);
        end
    end

    task automatic setin(input logic s, input logic b, input logic m, input logic t);
        Do_Stall = s; Branch_Taken_EX = b; Mem_Busy = m; Timeout_Clear = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        stall_bias = 32'd0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int burst;
        burst = 0;
        setin(0, 0, 0, 0);
        step();
        chk("rst_ctrl", 32'(dut_ctrl()), 32'h0000_00F0);
        chk("rst_stall", Stall_Cycles, 32'd0);
        chk("rst_flush", Flush_Count, 32'd0);
        step();
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Single load-use stall
        setin(1, 0, 0, 0); #1;
        chk("stall_ctrl", 32'(dut_ctrl()), 32'h0000_0034);
        step(); setin(0, 0, 0, 0); #1;
        chk("stall_count", Stall_Cycles, 32'd1);
        chk("stall_after_ctrl", 32'(dut_ctrl()), 32'h0000_00F0);

        // Branch overrides a coincident stall
        step(); rst_pulse();
        setin(1, 1, 0, 0); #1;
        chk("br_ctrl", 32'(dut_ctrl()), 32'h0000_00FC);
        step(); setin(0, 0, 0, 0); #1;
        chk("br_flush", Flush_Count, 32'd1);
        chk("br_stall", Stall_Cycles, 32'd0);

        // Memory stall with branch pending, then the branch is serviced
        step(); rst_pulse();
        for (int i = 0; i < 3; i++) begin
            setin(0, 1, 1, 0); #1;
            chk("mem_ctrl", 32'(dut_ctrl()), 32'h0000_0002);
            step();
        end
        setin(0, 1, 0, 0); #1;
        chk("mem_release_ctrl", 32'(dut_ctrl()), 32'h0000_00FC);
        step(); setin(0, 0, 0, 0); #1;
        chk("mem_stall", Stall_Cycles, 32'd3);
        chk("mem_flush", Flush_Count, 32'd1);

        // Timeout into HALT and out again
        step(); rst_pulse();
        for (int i = 0; i < 4; i++) begin
            setin(0, 0, 1, 0); #1;
            chk("to_not_halted", {31'd0, Halted}, 32'd0);
            step();
        end
        chk("to_halted", {31'd0, Halted}, 32'd1);
        chk("to_halt_ctrl", 32'(dut_ctrl()), 32'h0000_0001);
        setin(1, 1, 0, 1); #1;
        chk("to_clear_ctrl", 32'(dut_ctrl()), 32'h0000_0001);
        step(); setin(0, 0, 0, 0); #1;
        chk("to_run_ctrl", 32'(dut_ctrl()), 32'h0000_00F0);
        chk("to_stall", Stall_Cycles, 32'd5);

        // Stall counter wrap
        step(); rst_pulse();
        setin(0, 0, 0, 0); #1;
        force dut.u_stall_cnt.r_count = 32'hFFFF_FFFF;
        stall_bias = 32'hFFFF_FFFF - m_stall_inc;
        #1 release dut.u_stall_cnt.r_count;
        chk("wrap_preset", Stall_Cycles, 32'hFFFF_FFFF);
        step(); setin(1, 0, 0, 0);
        step(); setin(0, 0, 0, 0); #1;
        chk("wrap_zero", Stall_Cycles, 32'd0);

        // Reset in the middle of MEM_WAIT
        step(); rst_pulse();
        setin(0, 0, 1, 0);
        step(); step();
        rst_n = 1'b0;
        stall_bias = 32'd0;
        #1;
        chk("mwrst_halted", {31'd0, Halted}, 32'd0);
        chk("mwrst_stall", Stall_Cycles, 32'd0);
        chk("mwrst_flush", Flush_Count, 32'd0);
        rst_n = 1'b1;
        setin(0, 0, 0, 0); #1;
        chk("mwrst_ctrl", 32'(dut_ctrl()), 32'h0000_00F0);
        step();
        chk("mwrst_next_ctrl", 32'(dut_ctrl()), 32'h0000_00F0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic s, b, m, t;
            if (burst > 0) begin
                m = 1'b1;
                burst--;
            end else if ($urandom_range(0, 7) == 0) begin
                m = 1'b1;
                burst = int'($urandom_range(0, 5));
            end else begin
                m = 1'b0;
            end
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 9) < 2);
            t = ($urandom_range(0, 19) < 3);
            if ($urandom_range(0, 299) == 0) rst_pulse();
            setin(s, b, m, t);
            step();
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_control.md
PIPELINE_HAZARD_CONTROL -- requirements
Module: pipeline_hazard_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: number of consecutive Mem_Busy cycles that forces HALT; legal range 1..65535.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Do_Stall  input  1  load-use hazard request from the ID-stage stall checker (combinational, same cycle).
REQ-005 Branch_Taken_EX  input  1  taken branch/jump resolved in EX; the IF and ID instructions are wrong-path.
REQ-006 Mem_Busy  input  1  data memory cannot complete the MEM-stage access this cycle.
REQ-007 Timeout_Clear  input  1  single-cycle pulse; leaves HALT.
REQ-008 PC_Write_En, IF_ID_Write_En, ID_EX_Write_En, EX_MEM_Write_En  output  1 each  pipeline register load enables.
REQ-009 IF_ID_Flush, ID_EX_Bubble, MEM_WB_Bubble  output  1 each  force a NOP into the named register on this edge.
REQ-010 Halted  output  1  set while in HALT.
REQ-011 Stall_Cycles  output  32  count of cycles with PC_Write_En=0.
REQ-012 Flush_Count  output  32  count of cycles with IF_ID_Flush=1.

Function
REQ-013 The FSM SHALL have three states: RUN, MEM_WAIT, HALT; the control outputs SHALL be combinational from the state and the current inputs, with zero-cycle latency.
REQ-014 Priority SHALL be: HALT > Mem_Busy > Branch_Taken_EX > Do_Stall > normal flow.
REQ-015 Normal flow SHALL drive all four enables=1 and all flush/bubble outputs=0.
REQ-016 For Do_Stall alone: PC_Write_En=0, IF_ID_Write_En=0, ID_EX_Bubble=1, and ID_EX_Write_En=1, EX_MEM_Write_En=1.
REQ-017 For Branch_Taken_EX with Mem_Busy=0: all enables=1, IF_ID_Flush=1, ID_EX_Bubble=1; Do_Stall SHALL be ignored that cycle because the ID instruction is squashed.
REQ-018 For Mem_Busy=1, in RUN or MEM_WAIT: all four enables=0, MEM_WB_Bubble=1, IF_ID_Flush=0, ID_EX_Bubble=0; a pending branch or stall SHALL be serviced in the first cycle after Mem_Busy falls.
REQ-019 RUN->MEM_WAIT when Mem_Busy=1 at the clock edge; in this transition the 16-bit wait counter loads 1.
REQ-020 MEM_WAIT: while Mem_Busy=1, the counter SHALL increment; when Mem_Busy=1 and the counter equals MEM_TIMEOUT-1, the next state is HALT; when Mem_Busy=0, the next state is RUN and the counter clears.
REQ-021 HALT: all enables=0, all flush/bubble outputs=0, Halted=1; Timeout_Clear=1 -> RUN, counter cleared; all other inputs are ignored.
REQ-022 Stall_Cycles and Flush_Count SHALL increment by 1 on each qualifying edge, wrap from 0xFFFFFFFF to 0, and keep counting while in HALT (Stall_Cycles only).
REQ-023 If MEM_TIMEOUT=1, RUN with Mem_Busy=1 SHALL go directly to HALT.

Reset
REQ-024 When rst_n=0: state=RUN, wait counter=0, Stall_Cycles=0, Flush_Count=0, Halted=0.
REQ-025 Combinational outputs after reset SHALL follow REQ-015..018 immediately; reset asserted mid-MEM_WAIT or in HALT SHALL abandon the state without any extra bubble.

Structure
REQ-026 The state encoding enum and the default MEM_TIMEOUT constant SHALL reside in the shared pipeline package.
REQ-027 One sub-module, hazard_perf_counter (32-bit wrapping counter with enable), SHALL be instantiated twice; no other hierarchy is required.

Verification
REQ-028 Do_Stall=1 for 1 cycle -> PC_Write_En=0, IF_ID_Write_En=0, ID_EX_Bubble=1 that cycle; Stall_Cycles goes 0->1.
REQ-029 Branch_Taken_EX=1 together with Do_Stall=1 -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write_En=1; Flush_Count=1, Stall_Cycles=0.
REQ-030 Mem_Busy=1 for 3 cycles with Branch_Taken_EX held at 1 -> enables=0 and MEM_WB_Bubble=1 for 3 cycles, then 1 flush cycle; Stall_Cycles=3, Flush_Count=1.
REQ-031 MEM_TIMEOUT=4, Mem_Busy held at 1 -> HALT entered after the 4th edge, Halted=1; Timeout_Clear pulse -> RUN next cycle.
REQ-032 Stall_Cycles preset to 0xFFFFFFFF by force, plus one Do_Stall cycle -> Stall_Cycles=0x00000000.
REQ-033 rst_n pulsed low during MEM_WAIT (counter=2) -> state=RUN, counter=0, counters=0; Mem_Busy=0 -> normal flow on the next cycle.
